// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stream carrying bubble-gated control bits and pass-through datapath bits.
interface pipe_skid_reg_if #(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 175
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with optional 2-entry skid buffer, synchronous
// flush, bubble-gated control outputs and a saturating stall counter.
module pipe_skid_reg #(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 175,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    pipe_skid_reg_if.slave   up,
    pipe_skid_reg_if.master  down,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    occ_state_t        state_q;
    occ_state_t        state_d;
    logic              ready_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              out_valid;
    logic              accept;
    logic              consume;
    logic              load_out;
    logic              from_skid;
    logic              load_skid;

    assign out_valid = (state_q != EMPTY);

    // With the skid buffer in_ready is registered so it never depends on out_ready.
    assign up.ready  = (SKID != 0) ? ready_q : (!out_valid || down.ready);
    assign accept    = up.valid && up.ready;
    assign consume   = out_valid && down.ready;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        from_skid = 1'b0;
        load_skid = 1'b0;
        if (clr) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d  = ONE;
                        load_out = 1'b1;
                    end
                end
                ONE: begin
                    if (consume) begin
                        if (accept) begin
                            load_out = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (accept && (SKID != 0)) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_d   = ONE;
                        load_out  = 1'b1;
                        from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

    // Flush zeroes every register so a squashed instruction leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (clr) begin
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_out) begin
                ctrl_q <= from_skid ? skid_ctrl_q : up.ctrl;
                data_q <= from_skid ? skid_data_q : up.data;
            end
            if (load_skid) begin
                skid_ctrl_q <= up.ctrl;
                skid_data_q <= up.data;
            end else if (from_skid) begin
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !down.ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign down.valid = out_valid;
    assign down.ctrl  = out_valid ? ctrl_q : '0;
    assign down.data  = data_q;
    assign occ        = {state_q == TWO, state_q == ONE};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg (skid and non-skid builds)
// against queue-based reference models of the stage contents.
module tb_pipe_skid_reg;

    localparam int CW = 8;
    localparam int DW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_clr;
    logic          n_clr;
    logic [1:0]    s_occ;
    logic [1:0]    n_occ;
    logic [2:0]    s_cnt;
    logic [15:0]   n_cnt;

    int checks = 0;
    int errors = 0;

    logic [CW+DW-1:0] sq[$];
    logic [CW+DW-1:0] pq[$];
    int s_stall = 0;
    int p_stall = 0;

    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) s_up ();
    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) s_down ();
    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) n_up ();
    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) n_down ();

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(3)) u_skid (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .up(s_up), .down(s_down),
        .occ(s_occ), .stall_cnt(s_cnt)
    );

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_plain (
        .clk(clk), .rst_n(rst_n), .clr(n_clr), .up(n_up), .down(n_down),
        .occ(n_occ), .stall_cnt(n_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs follow from queue contents: front is the output entry.
    task automatic checkModels(input string phase);
        logic [CW+DW-1:0] f;
        checkOutput({phase, " s_valid"}, 32'(s_down.valid), 32'(sq.size() > 0));
        if (sq.size() > 0) begin
            f = sq[0];
            checkOutput({phase, " s_ctrl"}, 32'(s_down.ctrl), 32'(f[CW+DW-1:DW]));
            checkOutput({phase, " s_data"}, 32'(s_down.data), 32'(f[DW-1:0]));
        end else begin
            checkOutput({phase, " s_ctrl_bubble"}, 32'(s_down.ctrl), 32'(0));
        end
        checkOutput({phase, " s_occ"}, 32'(s_occ), 32'(sq.size()));
        checkOutput({phase, " s_in_ready"}, 32'(s_up.ready), 32'(sq.size() < 2));
        checkOutput({phase, " s_stall_cnt"}, 32'(s_cnt), 32'(s_stall));

        checkOutput({phase, " n_valid"}, 32'(n_down.valid), 32'(pq.size() > 0));
        if (pq.size() > 0) begin
            f = pq[0];
            checkOutput({phase, " n_ctrl"}, 32'(n_down.ctrl), 32'(f[CW+DW-1:DW]));
            checkOutput({phase, " n_data"}, 32'(n_down.data), 32'(f[DW-1:0]));
        end else begin
            checkOutput({phase, " n_ctrl_bubble"}, 32'(n_down.ctrl), 32'(0));
        end
        checkOutput({phase, " n_occ"}, 32'(n_occ), 32'(pq.size()));
        checkOutput({phase, " n_in_ready"}, 32'(n_up.ready), 32'((pq.size() == 0) || n_down.ready));
        checkOutput({phase, " n_stall_cnt"}, 32'(n_cnt), 32'(p_stall));
    endtask

    task automatic advance();
        bit s_acc, s_con, s_st, s_cl, p_acc, p_con, p_st, p_cl;
        logic [CW+DW-1:0] s_in, p_in;
        s_acc = s_up.valid && (sq.size() < 2);
        s_con = (sq.size() > 0) && s_down.ready;
        s_st  = (sq.size() > 0) && !s_down.ready;
        s_cl  = s_clr;
        s_in  = {s_up.ctrl, s_up.data};
        p_acc = n_up.valid && ((pq.size() == 0) || n_down.ready);
        p_con = (pq.size() > 0) && n_down.ready;
        p_st  = (pq.size() > 0) && !n_down.ready;
        p_cl  = n_clr;
        p_in  = {n_up.ctrl, n_up.data};
        @(posedge clk);
        if (s_st && s_stall < 7) s_stall++;
        if (p_st && p_stall < 65535) p_stall++;
        if (s_cl) sq.delete();
        else begin
            if (s_con) void'(sq.pop_front());
            if (s_acc) sq.push_back(s_in);
        end
        if (p_cl) pq.delete();
        else begin
            if (p_con) void'(pq.pop_front());
            if (p_acc) pq.push_back(p_in);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit sel, input bit v, input logic [DW-1:0] d,
                                 input bit ordy, input bit cl, input string phase);
        logic [CW-1:0] c;
        c = CW'($urandom);
        if (!sel) begin
            s_up.valid = v; s_up.ctrl = c; s_up.data = d; s_down.ready = ordy; s_clr = cl;
        end else begin
            n_up.valid = v; n_up.ctrl = c; n_up.data = d; n_down.ready = ordy; n_clr = cl;
        end
        #1;
        checkModels(phase);
        advance();
    endtask

    // Reset is asserted 1 ns after a falling edge to prove it acts asynchronously.
    task automatic doReset(input string phase);
        #1 rst_n = 1'b0;
        #1;
        sq.delete(); pq.delete();
        s_stall = 0; p_stall = 0;
        checkModels(phase);
        checkOutput({phase, " s_data_zero"}, 32'(s_down.data), 32'(0));
        checkOutput({phase, " n_data_zero"}, 32'(n_down.data), 32'(0));
        s_up.valid = 1'b0; s_down.ready = 1'b1; s_clr = 1'b0;
        n_up.valid = 1'b0; n_down.ready = 1'b1; n_clr = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        s_up.valid = 1'b0; s_up.ctrl = '0; s_up.data = '0; s_down.ready = 1'b1; s_clr = 1'b0;
        n_up.valid = 1'b0; n_up.ctrl = '0; n_up.data = '0; n_down.ready = 1'b1; n_clr = 1'b0;
        @(negedge clk);
        doReset("init");

        for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b1, 1'b0, "burst");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "burst_drain");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "burst_idle");

        applyStimulus(1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, "abc_a");
        applyStimulus(1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, "abc_b");
        applyStimulus(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, "abc_c_held");
        applyStimulus(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, "abc_c_held");
        applyStimulus(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, "abc_drain");
        applyStimulus(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, "abc_drain");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "abc_drain");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "abc_idle");

        applyStimulus(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, "clr_fill");
        applyStimulus(1'b0, 1'b1, 16'h0022, 1'b0, 1'b0, "clr_fill");
        applyStimulus(1'b0, 1'b1, 16'h0033, 1'b0, 1'b1, "clr_flush");
        checkOutput("clr s_data_zero", 32'(s_down.data), 32'(0));
        applyStimulus(1'b0, 1'b1, 16'h0044, 1'b1, 1'b0, "clr_accept");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "clr_latency");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "clr_idle");

        applyStimulus(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, "mid_fill");
        applyStimulus(1'b0, 1'b1, 16'h0066, 1'b0, 1'b0, "mid_fill");
        checkOutput("mid occ_full", 32'(s_occ), 32'(2));
        doReset("mid_reset");

        applyStimulus(1'b0, 1'b1, 16'h0077, 1'b0, 1'b0, "stall_load");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, "stall");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, "stall_clr");
        checkOutput("stall_hold", 32'(s_cnt), 32'(7));
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "stall_after");

        for (int i = 0; i < 2000; i++)
            applyStimulus(1'b0, 1'($urandom), DW'($urandom), 1'($urandom),
                          ($urandom_range(0, 31) == 0), "rand_skid");
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "rand_skid_end");

        for (int i = 0; i < 10000; i++)
            applyStimulus(1'b1, 1'($urandom), DW'($urandom), 1'($urandom),
                          ($urandom_range(0, 49) == 0), "rand_plain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
